qsram_refresh_array: RTL and testbench

//  Parametrised synchronous QSRAM array with a built-in refresh scheduler.

---
 rtl/qsram_refresh_array_if.sv | 30 +++
 rtl/qsram_refresh_array.sv | 110 +++++++++++
 tb/tb_qsram_refresh_array.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qsram_refresh_array_if.sv
// Request/response bundle between a bus master and the refreshing QSRAM array.
// The master drives requests and forced refresh; the array returns handshake, read data and refresh status.
interface qsram_refresh_array_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 8
);
    logic                             Enable;
    logic                             Read;
    logic                             Write;
    logic [ADDR_WIDTH-1:0]            Address;
    logic [DATA_WIDTH-1:0]            WriteData;
    logic [DATA_WIDTH/LANE_WIDTH-1:0] WriteMask;
    logic                             Refresh;
    logic                             Ready;
    logic [DATA_WIDTH-1:0]            ReadData;
    logic                             ReadValid;
    logic                             RefreshBusy;
    logic [ADDR_WIDTH-1:0]            RefreshRow;

    modport master (
        output Enable, Read, Write, Address, WriteData, WriteMask, Refresh,
        input  Ready, ReadData, ReadValid, RefreshBusy, RefreshRow
    );

    modport slave (
        input  Enable, Read, Write, Address, WriteData, WriteMask, Refresh,
        output Ready, ReadData, ReadValid, RefreshBusy, RefreshRow
    );
endinterface

// File: rtl/qsram_refresh_array.sv
// Synchronous QSRAM array with lane-masked writes, 1-cycle reads and a periodic refresh scheduler
// that stalls requests while a burst walks REFRESH_ROWS consecutive rows.
module qsram_refresh_array #(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 8,
    parameter int LANE_WIDTH       = 8,
    parameter int REFRESH_INTERVAL = 64,
    parameter int REFRESH_ROWS     = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    qsram_refresh_array_if.slave  bus
);
    localparam int LANES   = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int TIMER_W = $clog2(REFRESH_INTERVAL);
    localparam int COUNT_W = $clog2(REFRESH_ROWS) + 1;

    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(REFRESH_INTERVAL - 1);
    localparam logic [TIMER_W-1:0]    TIMER_ONE  = TIMER_W'(1);
    localparam logic [COUNT_W-1:0]    ROWS_LAST  = COUNT_W'(REFRESH_ROWS - 1);
    localparam logic [COUNT_W-1:0]    COUNT_ONE  = COUNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ROW_ONE    = ADDR_WIDTH'(1);

    typedef enum logic {IDLE, REFRESH} state_t;

    state_t                  state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [COUNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0]   row_q, row_d;
    logic                    read_valid_q, read_valid_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic trigger;
    logic ready;
    logic accept;

    always_comb begin
        trigger      = (state_q == IDLE) && ((timer_q == TIMER_LAST) || bus.Refresh);
        ready        = (state_q == IDLE) && !trigger && !Reset;
        accept       = bus.Enable && ready && (bus.Read || bus.Write);
        state_d      = state_q;
        timer_d      = timer_q;
        count_d      = count_q;
        row_d        = row_q;
        read_valid_d = accept && bus.Read;
        read_data_d  = read_data_q;
        // The array is sampled before this edge's write lands, giving read-before-write.
        if (accept && bus.Read) begin
            read_data_d = mem[bus.Address];
        end
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = REFRESH;
                    timer_d = '0;
                    count_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            REFRESH: begin
                timer_d = '0;
                row_d   = row_q + ROW_ONE;
                if (count_q == ROWS_LAST) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + COUNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            count_q      <= '0;
            row_q        <= '0;
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            row_q        <= row_d;
            read_valid_q <= read_valid_d;
            read_data_q  <= read_data_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive Reset.
    always_ff @(posedge Clock) begin
        if (accept && bus.Write) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.WriteMask[l]) begin
                    mem[bus.Address][l*LANE_WIDTH +: LANE_WIDTH] <= bus.WriteData[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    assign bus.Ready       = ready;
    assign bus.ReadData    = read_data_q;
    assign bus.ReadValid   = read_valid_q;
    assign bus.RefreshBusy = (state_q == REFRESH);
    assign bus.RefreshRow  = row_q;
endmodule

// File: tb/tb_qsram_refresh_array.sv
// Scoreboard bench for qsram_refresh_array: accepted reads queue their expected word, a monitor
// compares whenever ReadValid pulses; refresh timing is checked cycle by cycle against hand values.
module tb_qsram_refresh_array;
    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [15:0] expectedQueue [$];

    qsram_refresh_array_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8)) bus ();

    qsram_refresh_array #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8),
        .REFRESH_INTERVAL(8), .REFRESH_ROWS(4)
    ) dut (
        .Clock(clock),
        .Reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every ReadValid pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (bus.ReadValid === 1'b1) begin
            if (expectedQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedReadValid: got ReadData 0x%0h, expected no ReadValid", bus.ReadData);
            end else begin
                checkOutput("readData", {16'h0, bus.ReadData}, {16'h0, expectedQueue.pop_front()});
            end
        end
    end

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic doReset();
        reset         = 1'b1;
        bus.Enable    = 1'b0;
        bus.Read      = 1'b0;
        bus.Write     = 1'b0;
        bus.Refresh   = 1'b0;
        @(negedge clock);
        checkOutput("readyDuringReset", {31'h0, bus.Ready}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Issue one request, hold it until Ready, queue the expected read word on acceptance.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] addr,
                                 input logic [15:0] data, input logic [1:0] mask,
                                 input logic [15:0] expRead);
        bit accepted;
        accepted      = 1'b0;
        bus.Enable    = 1'b1;
        bus.Read      = rd;
        bus.Write     = wr;
        bus.Address   = addr;
        bus.WriteData = data;
        bus.WriteMask = mask;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clock);
            if (bus.Ready === 1'b1) accepted = 1'b1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        if (!accepted) begin
            checkOutput("acceptTimeout", 32'h0, 32'h1);
        end else begin
            if (rd) expectedQueue.push_back(expRead);
            @(posedge clock);
            #1;
        end
        bus.Enable = 1'b0;
        bus.Read   = 1'b0;
        bus.Write  = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        bus.Enable    = 1'b0;
        bus.Read      = 1'b0;
        bus.Write     = 1'b0;
        bus.Address   = '0;
        bus.WriteData = '0;
        bus.WriteMask = '0;
        bus.Refresh   = 1'b0;
        @(posedge clock);
        #1;

        // Reset state
        doReset();
        @(negedge clock);
        checkOutput("resetReady", {31'h0, bus.Ready}, 32'h1);
        checkOutput("resetReadValid", {31'h0, bus.ReadValid}, 32'h0);
        checkOutput("resetReadData", {16'h0, bus.ReadData}, 32'h0);
        checkOutput("resetBusy", {31'h0, bus.RefreshBusy}, 32'h0);
        checkOutput("resetRow", {28'h0, bus.RefreshRow}, 32'h0);
        @(posedge clock);
        #1;

        // Test 1: simple write then read, single-cycle ReadValid
        $display("[TB] test 1: write/read");
        doReset();
        applyStimulus(1'b0, 1'b1, 4'd3, 16'h00A5, 2'b11, 16'h0);
        applyStimulus(1'b1, 1'b0, 4'd3, 16'h0, 2'b00, 16'h00A5);
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("readValidPulse", {31'h0, bus.ReadValid}, 32'h0);
        checkOutput("readDataHold", {16'h0, bus.ReadData}, 32'h00A5);
        @(posedge clock);
        #1;

        // Test 2: lane-masked partial write
        $display("[TB] test 2: write mask");
        doReset();
        applyStimulus(1'b0, 1'b1, 4'd7, 16'h1234, 2'b11, 16'h0);
        applyStimulus(1'b0, 1'b1, 4'd7, 16'hABCD, 2'b01, 16'h0);
        applyStimulus(1'b1, 1'b0, 4'd7, 16'h0, 2'b00, 16'h12CD);
        applyStimulus(1'b0, 1'b1, 4'd7, 16'h5678, 2'b00, 16'h0);
        applyStimulus(1'b1, 1'b0, 4'd7, 16'h0, 2'b00, 16'h12CD);
        idleCycles(2);

        // Test 3: read-before-write in the same request
        $display("[TB] test 3: read-before-write");
        doReset();
        applyStimulus(1'b0, 1'b1, 4'd5, 16'h0011, 2'b11, 16'h0);
        applyStimulus(1'b1, 1'b1, 4'd5, 16'h0022, 2'b11, 16'h0011);
        applyStimulus(1'b1, 1'b0, 4'd5, 16'h0, 2'b00, 16'h0022);
        idleCycles(2);

        // Test 4: automatic bursts every 8 idle cycles, rows 0..3 then 4..7
        $display("[TB] test 4: periodic refresh");
        doReset();
        bus.Enable = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 7; i++) begin
                @(negedge clock);
                checkOutput($sformatf("burst%0dReady%0d", b, i), {31'h0, bus.Ready}, 32'h1);
                checkOutput($sformatf("burst%0dIdleBusy%0d", b, i), {31'h0, bus.RefreshBusy}, 32'h0);
                @(posedge clock);
                #1;
            end
            @(negedge clock);
            checkOutput($sformatf("burst%0dTriggerReady", b), {31'h0, bus.Ready}, 32'h0);
            checkOutput($sformatf("burst%0dTriggerBusy", b), {31'h0, bus.RefreshBusy}, 32'h0);
            @(posedge clock);
            #1;
            for (int r = 0; r < 4; r++) begin
                @(negedge clock);
                checkOutput($sformatf("burst%0dBusy%0d", b, r), {31'h0, bus.RefreshBusy}, 32'h1);
                checkOutput($sformatf("burst%0dReadyLow%0d", b, r), {31'h0, bus.Ready}, 32'h0);
                checkOutput($sformatf("burst%0dRow%0d", b, r), {28'h0, bus.RefreshRow}, 32'(4 * b + r));
                @(posedge clock);
                #1;
            end
        end
        @(negedge clock);
        checkOutput("afterBurstsRow", {28'h0, bus.RefreshRow}, 32'h8);
        checkOutput("afterBurstsBusy", {31'h0, bus.RefreshBusy}, 32'h0);
        @(posedge clock);
        #1;
        bus.Enable = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'd3, 16'h0, 2'b00, 16'h00A5);
        applyStimulus(1'b1, 1'b0, 4'd7, 16'h0, 2'b00, 16'h12CD);
        idleCycles(2);

        // Test 5: forced refresh collides with a read; read waits out the burst
        $display("[TB] test 5: forced refresh");
        doReset();
        bus.Enable  = 1'b1;
        bus.Read    = 1'b1;
        bus.Address = 4'd5;
        bus.Refresh = 1'b1;
        @(negedge clock);
        checkOutput("forceReady", {31'h0, bus.Ready}, 32'h0);
        @(posedge clock);
        #1;
        bus.Refresh = 1'b0;
        for (int r = 0; r < 4; r++) begin
            @(negedge clock);
            checkOutput($sformatf("forceBusy%0d", r), {31'h0, bus.RefreshBusy}, 32'h1);
            checkOutput($sformatf("forceRow%0d", r), {28'h0, bus.RefreshRow}, 32'(r));
            checkOutput($sformatf("forceReadyLow%0d", r), {31'h0, bus.Ready}, 32'h0);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        checkOutput("forceReadyAfter", {31'h0, bus.Ready}, 32'h1);
        if (bus.Ready === 1'b1) expectedQueue.push_back(16'h0022);
        @(posedge clock);
        #1;
        bus.Enable = 1'b0;
        bus.Read   = 1'b0;
        idleCycles(2);

        // Test 6: reset in the middle of a burst
        $display("[TB] test 6: reset mid-burst");
        doReset();
        bus.Refresh = 1'b1;
        @(posedge clock);
        #1;
        bus.Refresh = 1'b0;
        @(negedge clock);
        checkOutput("midBurstRow0", {28'h0, bus.RefreshRow}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midBurstBusy", {31'h0, bus.RefreshBusy}, 32'h1);
        checkOutput("midBurstRow1", {28'h0, bus.RefreshRow}, 32'h1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("postResetBusy", {31'h0, bus.RefreshBusy}, 32'h0);
        checkOutput("postResetRow", {28'h0, bus.RefreshRow}, 32'h0);
        checkOutput("postResetReady", {31'h0, bus.Ready}, 32'h1);
        checkOutput("postResetReadData", {16'h0, bus.ReadData}, 32'h0);
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 1'b0, 4'd5, 16'h0, 2'b00, 16'h0022);
        applyStimulus(1'b1, 1'b0, 4'd3, 16'h0, 2'b00, 16'h00A5);
        idleCycles(3);

        checkOutput("queueDrained", 32'(expectedQueue.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
